// File: rtl/enet_ddr_arb_pkg.sv
// Shared types for the ethernet/host DDR arbiter: FSM state encoding and port ids.
package enet_ddr_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } arb_state_e;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

endpackage

// File: rtl/enet_arb_tag_fifo.sv
// Read-tag FIFO: remembers which port issued each outstanding DDR read, in issue order.
module enet_arb_tag_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic                     i_push_id,
   input  logic                     i_pop,
   output logic                     o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign o_full  = (count_q == FULL_CNT);
   assign o_empty = (count_q == '0);
   assign o_head  = mem_q[rd_ptr_q];
   assign o_count = count_q;

   // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      do_push  = i_push & ~o_full;
      do_pop   = i_pop & ~o_empty;
      if (do_push) begin
         mem_d[wr_ptr_q] = i_push_id;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
   end

   // NOTE: sequential state is written with <= so all flops update together from pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: tag storage is not reset; the count masks stale entries, so only pointers need clearing.
   always_ff @(posedge i_clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/enet_ddr_arbiter.sv
// Round-robin arbiter sharing one DDR controller user port between ethernet DMA (port 0)
// and host logic (port 1); returning read data is steered by the tag FIFO.
module enet_ddr_arbiter
   import enet_ddr_arb_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 256,
   parameter int TAG_DEPTH = 16
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_p0_wr_req,
   input  logic                        i_p0_rd_req,
   input  logic [DATA_W-1:0]           i_p0_wr_data,
   input  logic [DATA_W/8-1:0]         i_p0_wr_be,
   input  logic [ADDR_W-1:0]           i_p0_wr_addr,
   input  logic [ADDR_W-1:0]           i_p0_rd_addr,
   output logic                        o_p0_wr_ack,
   output logic                        o_p0_rd_ack,
   output logic [DATA_W-1:0]           o_p0_rd_data,
   output logic                        o_p0_rd_data_valid,
   input  logic                        i_p1_wr_req,
   input  logic                        i_p1_rd_req,
   input  logic [DATA_W-1:0]           i_p1_wr_data,
   input  logic [DATA_W/8-1:0]         i_p1_wr_be,
   input  logic [ADDR_W-1:0]           i_p1_wr_addr,
   input  logic [ADDR_W-1:0]           i_p1_rd_addr,
   output logic                        o_p1_wr_ack,
   output logic                        o_p1_rd_ack,
   output logic [DATA_W-1:0]           o_p1_rd_data,
   output logic                        o_p1_rd_data_valid,
   output logic                        o_ddr_wr_req,
   output logic                        o_ddr_rd_req,
   output logic [DATA_W-1:0]           o_ddr_wr_data,
   output logic [DATA_W/8-1:0]         o_ddr_wr_be,
   output logic [ADDR_W-1:0]           o_ddr_wr_addr,
   output logic [ADDR_W-1:0]           o_ddr_rd_addr,
   input  logic                        i_ddr_wr_ack,
   input  logic                        i_ddr_rd_ack,
   input  logic [DATA_W-1:0]           i_ddr_rd_data,
   input  logic                        i_ddr_rd_data_valid,
   output logic [$clog2(TAG_DEPTH):0]  o_outstanding
);

   arb_state_e            state_q, state_d;
   logic                  grant_q, grant_d;
   logic                  rr_q, rr_d;
   logic                  wr_req_q, wr_req_d;
   logic                  rd_req_q, rd_req_d;
   logic [DATA_W-1:0]     wr_data_q, wr_data_d;
   logic [DATA_W/8-1:0]   wr_be_q, wr_be_d;
   logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
   logic [ADDR_W-1:0]     rd_addr_q, rd_addr_d;

   logic                  fifo_full, fifo_empty, fifo_head;
   logic                  p0_elig, p1_elig, sel;
   logic                  wr_done, rd_done, rd_valid;

   assign wr_done  = i_ddr_wr_ack & (state_q == WR);
   assign rd_done  = i_ddr_rd_ack & (state_q == RD);
   assign rd_valid = i_ddr_rd_data_valid & ~fifo_empty;

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_d      = rr_q;
      wr_req_d  = wr_req_q;
      rd_req_d  = rd_req_q;
      wr_data_d = wr_data_q;
      wr_be_d   = wr_be_q;
      wr_addr_d = wr_addr_q;
      rd_addr_d = rd_addr_q;

      p0_elig = i_p0_wr_req | (i_p0_rd_req & ~fifo_full);
      p1_elig = i_p1_wr_req | (i_p1_rd_req & ~fifo_full);
      // rr_q holds the last granted port; the other one wins a tie.
      sel = P0;
      if (p0_elig & p1_elig) begin
         sel = (rr_q == P0) ? P1 : P0;
      end else if (p1_elig) begin
         sel = P1;
      end

      case (state_q)
         IDLE: begin
            if (p0_elig | p1_elig) begin
               grant_d = sel;
               if ((sel == P1) ? i_p1_wr_req : i_p0_wr_req) begin
                  state_d   = WR;
                  wr_req_d  = 1'b1;
                  wr_data_d = (sel == P1) ? i_p1_wr_data : i_p0_wr_data;
                  wr_be_d   = (sel == P1) ? i_p1_wr_be   : i_p0_wr_be;
                  wr_addr_d = (sel == P1) ? i_p1_wr_addr : i_p0_wr_addr;
               end else begin
                  state_d   = RD;
                  rd_req_d  = 1'b1;
                  rd_addr_d = (sel == P1) ? i_p1_rd_addr : i_p0_rd_addr;
               end
            end
         end
         WR: begin
            if (i_ddr_wr_ack) begin
               state_d  = IDLE;
               wr_req_d = 1'b0;
               rr_d     = grant_q;
            end
         end
         RD: begin
            if (i_ddr_rd_ack) begin
               state_d  = IDLE;
               rd_req_d = 1'b0;
               rr_d     = grant_q;
            end
         end
         default: begin
            state_d  = IDLE;
            wr_req_d = 1'b0;
            rd_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         grant_q   <= P0;
         rr_q      <= P0;
         wr_req_q  <= 1'b0;
         rd_req_q  <= 1'b0;
         wr_data_q <= '0;
         wr_be_q   <= '0;
         wr_addr_q <= '0;
         rd_addr_q <= '0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_q      <= rr_d;
         wr_req_q  <= wr_req_d;
         rd_req_q  <= rd_req_d;
         wr_data_q <= wr_data_d;
         wr_be_q   <= wr_be_d;
         wr_addr_q <= wr_addr_d;
         rd_addr_q <= rd_addr_d;
      end
   end

   enet_arb_tag_fifo #(
      .DEPTH (TAG_DEPTH)
   ) u_tag_fifo (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_push    (rd_done),
      .i_push_id (grant_q),
      .i_pop     (i_ddr_rd_data_valid),
      .o_head    (fifo_head),
      .o_full    (fifo_full),
      .o_empty   (fifo_empty),
      .o_count   (o_outstanding)
   );

   // Acks are suppressed for a requester that abandoned its request mid-transaction.
   assign o_p0_wr_ack = wr_done & (grant_q == P0) & i_p0_wr_req;
   assign o_p1_wr_ack = wr_done & (grant_q == P1) & i_p1_wr_req;
   assign o_p0_rd_ack = rd_done & (grant_q == P0) & i_p0_rd_req;
   assign o_p1_rd_ack = rd_done & (grant_q == P1) & i_p1_rd_req;

   assign o_p0_rd_data       = i_ddr_rd_data;
   assign o_p1_rd_data       = i_ddr_rd_data;
   assign o_p0_rd_data_valid = rd_valid & (fifo_head == P0);
   assign o_p1_rd_data_valid = rd_valid & (fifo_head == P1);

   assign o_ddr_wr_req  = wr_req_q;
   assign o_ddr_rd_req  = rd_req_q;
   assign o_ddr_wr_data = wr_data_q;
   assign o_ddr_wr_be   = wr_be_q;
   assign o_ddr_wr_addr = wr_addr_q;
   assign o_ddr_rd_addr = rd_addr_q;

endmodule

// File: tb/tb_enet_ddr_arbiter.sv
// Directed bench for enet_ddr_arbiter: inputs change and outputs are sampled on the falling edge.
module tb_enet_ddr_arbiter;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 256;
   localparam int BE_W      = DATA_W / 8;
   localparam int TAG_DEPTH = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                p0_wr_req, p0_rd_req, p1_wr_req, p1_rd_req;
   logic [DATA_W-1:0]   p0_wr_data, p1_wr_data;
   logic [BE_W-1:0]     p0_wr_be, p1_wr_be;
   logic [ADDR_W-1:0]   p0_wr_addr, p0_rd_addr, p1_wr_addr, p1_rd_addr;
   logic                p0_wr_ack, p0_rd_ack, p1_wr_ack, p1_rd_ack;
   logic [DATA_W-1:0]   p0_rd_data, p1_rd_data;
   logic                p0_rd_valid, p1_rd_valid;
   logic                ddr_wr_req, ddr_rd_req;
   logic [DATA_W-1:0]   ddr_wr_data;
   logic [BE_W-1:0]     ddr_wr_be;
   logic [ADDR_W-1:0]   ddr_wr_addr, ddr_rd_addr;
   logic                ddr_wr_ack, ddr_rd_ack, ddr_rd_valid;
   logic [DATA_W-1:0]   ddr_rd_data;
   logic [$clog2(TAG_DEPTH):0] outstanding;

   int n_vec = 0;
   int n_err = 0;
   logic [DATA_W-1:0] pat_a, pat_b;

   always #5 clk = ~clk;

   enet_ddr_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .TAG_DEPTH (TAG_DEPTH)
   ) dut (
      .i_clk               (clk),
      .i_rst               (rst),
      .i_p0_wr_req         (p0_wr_req),
      .i_p0_rd_req         (p0_rd_req),
      .i_p0_wr_data        (p0_wr_data),
      .i_p0_wr_be          (p0_wr_be),
      .i_p0_wr_addr        (p0_wr_addr),
      .i_p0_rd_addr        (p0_rd_addr),
      .o_p0_wr_ack         (p0_wr_ack),
      .o_p0_rd_ack         (p0_rd_ack),
      .o_p0_rd_data        (p0_rd_data),
      .o_p0_rd_data_valid  (p0_rd_valid),
      .i_p1_wr_req         (p1_wr_req),
      .i_p1_rd_req         (p1_rd_req),
      .i_p1_wr_data        (p1_wr_data),
      .i_p1_wr_be          (p1_wr_be),
      .i_p1_wr_addr        (p1_wr_addr),
      .i_p1_rd_addr        (p1_rd_addr),
      .o_p1_wr_ack         (p1_wr_ack),
      .o_p1_rd_ack         (p1_rd_ack),
      .o_p1_rd_data        (p1_rd_data),
      .o_p1_rd_data_valid  (p1_rd_valid),
      .o_ddr_wr_req        (ddr_wr_req),
      .o_ddr_rd_req        (ddr_rd_req),
      .o_ddr_wr_data       (ddr_wr_data),
      .o_ddr_wr_be         (ddr_wr_be),
      .o_ddr_wr_addr       (ddr_wr_addr),
      .o_ddr_rd_addr       (ddr_rd_addr),
      .i_ddr_wr_ack        (ddr_wr_ack),
      .i_ddr_rd_ack        (ddr_rd_ack),
      .i_ddr_rd_data       (ddr_rd_data),
      .i_ddr_rd_data_valid (ddr_rd_valid),
      .o_outstanding       (outstanding)
   );

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      pat_a = {8{32'hA5A5_0001}};
      pat_b = {8{32'h5A5A_0002}};
      rst = 1'b1;
      p0_wr_req = 1'b0; p0_rd_req = 1'b0; p1_wr_req = 1'b0; p1_rd_req = 1'b0;
      p0_wr_data = '0; p1_wr_data = '0; p0_wr_be = '0; p1_wr_be = '0;
      p0_wr_addr = '0; p0_rd_addr = '0; p1_wr_addr = '0; p1_rd_addr = '0;
      ddr_wr_ack = 1'b0; ddr_rd_ack = 1'b0; ddr_rd_valid = 1'b0; ddr_rd_data = '0;

      // reset state
      repeat (2) @(negedge clk);
      check("rst_wr_req", 256'(ddr_wr_req), 256'd0);
      check("rst_rd_req", 256'(ddr_rd_req), 256'd0);
      check("rst_wr_addr", 256'(ddr_wr_addr), 256'd0);
      check("rst_wr_data", 256'(ddr_wr_data), 256'd0);
      check("rst_wr_be", 256'(ddr_wr_be), 256'd0);
      check("rst_outst", 256'(outstanding), 256'd0);
      rst = 1'b0;

      // single p0 write, DDR acks in the third request cycle
      @(negedge clk);
      p0_wr_req = 1'b1; p0_wr_addr = 32'h100; p0_wr_be = 32'hFFFF_FFFF; p0_wr_data = pat_a;
      #1 check("wr_c0_req", 256'(ddr_wr_req), 256'd0);
      @(negedge clk);
      check("wr_c1_req", 256'(ddr_wr_req), 256'd1);
      check("wr_c1_addr", 256'(ddr_wr_addr), 256'h100);
      check("wr_c1_data", 256'(ddr_wr_data), 256'(pat_a));
      check("wr_c1_be", 256'(ddr_wr_be), 256'hFFFF_FFFF);
      check("wr_c1_ack", 256'(p0_wr_ack), 256'd0);
      p0_wr_addr = 32'hDEAD;
      @(negedge clk);
      check("wr_c2_req", 256'(ddr_wr_req), 256'd1);
      check("wr_c2_hold", 256'(ddr_wr_addr), 256'h100);
      @(negedge clk);
      ddr_wr_ack = 1'b1;
      #1 check("wr_c3_p0ack", 256'(p0_wr_ack), 256'd1);
      check("wr_c3_p1ack", 256'(p1_wr_ack), 256'd0);
      @(negedge clk);
      ddr_wr_ack = 1'b0; p0_wr_req = 1'b0;
      #1 check("wr_c4_req", 256'(ddr_wr_req), 256'd0);
      check("wr_c4_ack", 256'(p0_wr_ack), 256'd0);

      // read routing: p0 then p1, data returns in order
      p0_rd_req = 1'b1; p0_rd_addr = 32'h200;
      @(negedge clk);
      check("rd0_req", 256'(ddr_rd_req), 256'd1);
      check("rd0_addr", 256'(ddr_rd_addr), 256'h200);
      check("rd0_outst", 256'(outstanding), 256'd0);
      ddr_rd_ack = 1'b1;
      #1 check("rd0_p0ack", 256'(p0_rd_ack), 256'd1);
      check("rd0_p1ack", 256'(p1_rd_ack), 256'd0);
      @(negedge clk);
      ddr_rd_ack = 1'b0; p0_rd_req = 1'b0; p1_rd_req = 1'b1; p1_rd_addr = 32'h300;
      #1 check("rd_outst1", 256'(outstanding), 256'd1);
      check("rd_idle", 256'(ddr_rd_req), 256'd0);
      @(negedge clk);
      check("rd1_addr", 256'(ddr_rd_addr), 256'h300);
      ddr_rd_ack = 1'b1;
      #1 check("rd1_p1ack", 256'(p1_rd_ack), 256'd1);
      check("rd1_p0ack", 256'(p0_rd_ack), 256'd0);
      @(negedge clk);
      ddr_rd_ack = 1'b0; p1_rd_req = 1'b0;
      #1 check("rd_outst2", 256'(outstanding), 256'd2);
      ddr_rd_valid = 1'b1; ddr_rd_data = pat_a;
      #1 check("rdv0_p0", 256'(p0_rd_valid), 256'd1);
      check("rdv0_p1", 256'(p1_rd_valid), 256'd0);
      check("rdv0_data", 256'(p0_rd_data), 256'(pat_a));
      @(negedge clk);
      ddr_rd_data = pat_b;
      #1 check("rd_outst1b", 256'(outstanding), 256'd1);
      check("rdv1_p1", 256'(p1_rd_valid), 256'd1);
      check("rdv1_p0", 256'(p0_rd_valid), 256'd0);
      check("rdv1_data", 256'(p1_rd_data), 256'(pat_b));
      @(negedge clk);
      ddr_rd_valid = 1'b0;
      #1 check("rd_outst0", 256'(outstanding), 256'd0);

      // contention: last grant was P1, so P0 goes first, then strict alternation
      p0_wr_req = 1'b1; p0_wr_addr = 32'h10; p1_wr_req = 1'b1; p1_wr_addr = 32'h20;
      for (int g = 0; g < 4; g++) begin
         @(negedge clk);
         check("cont_req", 256'(ddr_wr_req), 256'd1);
         check("cont_addr", 256'(ddr_wr_addr), (g % 2 == 0) ? 256'h10 : 256'h20);
         ddr_wr_ack = 1'b1;
         #1 check("cont_p0ack", 256'(p0_wr_ack), 256'(g % 2 == 0));
         check("cont_p1ack", 256'(p1_wr_ack), 256'(g % 2 == 1));
         @(negedge clk);
         ddr_wr_ack = 1'b0;
         #1 check("cont_idle", 256'(ddr_wr_req), 256'd0);
      end
      p0_wr_req = 1'b0; p1_wr_req = 1'b0;

      // same-port priority: write before read
      @(negedge clk);
      p0_wr_req = 1'b1; p0_rd_req = 1'b1; p0_wr_addr = 32'h700; p0_rd_addr = 32'h800;
      @(negedge clk);
      check("prio_wr", 256'(ddr_wr_req), 256'd1);
      check("prio_nord", 256'(ddr_rd_req), 256'd0);
      ddr_wr_ack = 1'b1;
      #1 check("prio_wrack", 256'(p0_wr_ack), 256'd1);
      check("prio_rdack0", 256'(p0_rd_ack), 256'd0);
      @(negedge clk);
      ddr_wr_ack = 1'b0; p0_wr_req = 1'b0;
      #1 check("prio_idle_wr", 256'(ddr_wr_req), 256'd0);
      check("prio_idle_rd", 256'(ddr_rd_req), 256'd0);
      @(negedge clk);
      check("prio_rd", 256'(ddr_rd_req), 256'd1);
      check("prio_rdaddr", 256'(ddr_rd_addr), 256'h800);
      ddr_rd_ack = 1'b1;
      #1 check("prio_rdack", 256'(p0_rd_ack), 256'd1);
      @(negedge clk);
      ddr_rd_ack = 1'b0; p0_rd_req = 1'b0;
      #1 check("prio_outst", 256'(outstanding), 256'd1);
      ddr_rd_valid = 1'b1; ddr_rd_data = pat_b;
      #1 check("prio_rdv", 256'(p0_rd_valid), 256'd1);
      @(negedge clk);
      ddr_rd_valid = 1'b0;
      #1 check("prio_outst0", 256'(outstanding), 256'd0);

      // FIFO full: four p1 reads fill it, the fifth waits for a data beat
      @(negedge clk);
      p1_rd_req = 1'b1; p1_rd_addr = 32'h400;
      for (int r = 0; r < 4; r++) begin
         @(negedge clk);
         check("full_outst", 256'(outstanding), 256'(r));
         ddr_rd_ack = 1'b1;
         #1 check("full_p1ack", 256'(p1_rd_ack), 256'd1);
         @(negedge clk);
         ddr_rd_ack = 1'b0;
         #1 check("full_idle", 256'(ddr_rd_req), 256'd0);
      end
      check("full_cnt", 256'(outstanding), 256'd4);
      p0_wr_req = 1'b1; p0_wr_addr = 32'h500;
      @(negedge clk);
      check("full_wr", 256'(ddr_wr_req), 256'd1);
      check("full_wr_nord", 256'(ddr_rd_req), 256'd0);
      ddr_wr_ack = 1'b1;
      #1 check("full_wrack", 256'(p0_wr_ack), 256'd1);
      @(negedge clk);
      ddr_wr_ack = 1'b0; p0_wr_req = 1'b0;
      #1 check("full_blk0", 256'(ddr_rd_req), 256'd0);
      repeat (2) begin
         @(negedge clk);
         check("full_blk", 256'(ddr_rd_req), 256'd0);
      end
      ddr_rd_valid = 1'b1; ddr_rd_data = pat_a;
      #1 check("full_pop_p1", 256'(p1_rd_valid), 256'd1);
      check("full_pop_p0", 256'(p0_rd_valid), 256'd0);
      @(negedge clk);
      ddr_rd_valid = 1'b0;
      #1 check("full_cnt3", 256'(outstanding), 256'd3);
      check("full_norq", 256'(ddr_rd_req), 256'd0);
      @(negedge clk);
      check("full_5th", 256'(ddr_rd_req), 256'd1);
      ddr_rd_ack = 1'b1;
      #1 check("full_5th_ack", 256'(p1_rd_ack), 256'd1);
      @(negedge clk);
      ddr_rd_ack = 1'b0; p1_rd_req = 1'b0;
      #1 check("full_cnt4b", 256'(outstanding), 256'd4);

      // drain to two outstanding, then reset in the middle of a read
      ddr_rd_valid = 1'b1; ddr_rd_data = pat_b;
      @(negedge clk);
      check("drain_cnt3", 256'(outstanding), 256'd3);
      @(negedge clk);
      ddr_rd_valid = 1'b0;
      #1 check("drain_cnt2", 256'(outstanding), 256'd2);
      p0_rd_req = 1'b1; p0_rd_addr = 32'h600;
      @(negedge clk);
      check("mid_rdreq", 256'(ddr_rd_req), 256'd1);
      check("mid_rdaddr", 256'(ddr_rd_addr), 256'h600);
      ddr_wr_ack = 1'b1;
      #1 check("mid_wrack_ign", 256'(p0_wr_ack), 256'd0);
      check("mid_rdack_none", 256'(p0_rd_ack), 256'd0);
      @(negedge clk);
      ddr_wr_ack = 1'b0;
      #1 check("mid_still_rd", 256'(ddr_rd_req), 256'd1);
      check("mid_cnt2", 256'(outstanding), 256'd2);
      rst = 1'b1; p0_rd_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1 check("rst_mid_rdreq", 256'(ddr_rd_req), 256'd0);
      check("rst_mid_outst", 256'(outstanding), 256'd0);
      ddr_rd_valid = 1'b1; ddr_rd_data = pat_a;
      #1 check("late_p0v", 256'(p0_rd_valid), 256'd0);
      check("late_p1v", 256'(p1_rd_valid), 256'd0);
      @(negedge clk);
      ddr_rd_valid = 1'b0;
      #1 check("late_outst", 256'(outstanding), 256'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/enet_ddr_arbiter.md
Name: enet_ddr_arbiter

Overview:
Shares the single DDR controller user port between two requesters.
- Port 0: ethernet DMA engine.
- Port 1: host/PCIe user logic.

Arbitration is round-robin with one transaction granted at a time. A read-tag FIFO routes returning read data back to the requester that issued the read. It sits between the ethernet top-level DDR signals and the DDR controller.

Parameters:
ADDR_W, 32, DDR byte address width
DATA_W, 256, DDR data width; byte-enable width is DATA_W/8
TAG_DEPTH, 16, max outstanding reads (power of 2, >=2)

Ports:
i_clk  in  1  system clock, single domain
i_rst  in  1  reset, synchronous, active-high
i_p0_wr_req  in  1  port0 write request, held until ack
i_p0_rd_req  in  1  port0 read request, held until ack
i_p0_wr_data  in  DATA_W  port0 write data
i_p0_wr_be  in  DATA_W/8  port0 byte enables
i_p0_wr_addr  in  ADDR_W  port0 write address
i_p0_rd_addr  in  ADDR_W  port0 read address
o_p0_wr_ack  out  1  port0 write accepted (1-cycle pulse)
o_p0_rd_ack  out  1  port0 read accepted (1-cycle pulse)
o_p0_rd_data  out  DATA_W  port0 read data
o_p0_rd_data_valid  out  1  port0 read data valid
i_p1_* / o_p1_*  same set as port0, for port1
o_ddr_wr_req  out  1  to DDR controller
o_ddr_rd_req  out  1  to DDR controller
o_ddr_wr_data  out  DATA_W
o_ddr_wr_be  out  DATA_W/8
o_ddr_wr_addr  out  ADDR_W
o_ddr_rd_addr  out  ADDR_W
i_ddr_wr_ack  in  1
i_ddr_rd_ack  in  1
i_ddr_rd_data  in  DATA_W
i_ddr_rd_data_valid  in  1
o_outstanding  out  $clog2(TAG_DEPTH)+1  reads in flight (debug/status)

Behaviour:
- Reset values: all req/ack/valid outputs 0; DDR data/addr/be 0; o_outstanding 0; RR pointer = port0; state IDLE; tag FIFO empty.
- Clocking and reset: single clock i_clk; reset i_rst is synchronous, active-high.
- States:
  - IDLE: winner chosen among ports with (wr_req|rd_req). Round-robin: the port after the last granted port has priority. Within a port, write beats read. A read is eligible only if the tag FIFO is not full.
  - WR: o_ddr_wr_req=1 with the winner's data/be/addr registered at grant.
  - RD: o_ddr_rd_req=1 with the winner's rd_addr registered.
- Latency: IDLE->WR/RD takes 1 cycle; DDR req is asserted in the cycle after the requester's req is sampled.
- Handshake:
  - o_pX_wr_ack = i_ddr_wr_ack & (state==WR) & (grant==X), combinational pass-through.
  - rd_ack follows the same rule with RD.
  - On ack the state returns to IDLE and the DDR req is 0 the next cycle (never two back-to-back grants without an IDLE cycle).
  - RR pointer updates to the granted port on ack.
- DDR outputs are held stable while req=1.
- Ack in a non-matching state (e.g. wr_ack during RD) is ignored.
- Tag FIFO (TAG_DEPTH x 1 bit):
  - Push the grant id on rd_ack.
  - Pop on i_ddr_rd_data_valid.
  - Head bit steers valid: o_pX_rd_data_valid = valid & (head==X).
  - Read data is fanned to both ports unregistered (0-cycle).
- Simultaneous push and pop: both happen; count unchanged.
- o_outstanding = FIFO count. Full (count==TAG_DEPTH) blocks read grants; writes still proceed.
- Error cases:
  - rd_data_valid with FIFO empty: data dropped, no port valid, count stays 0 (no underflow).
  - Requester dropping req before ack is illegal; the arbiter completes the DDR transaction regardless and suppresses the ack if the req is gone.
- Reset mid-transaction: DDR req drops next cycle and the FIFO is cleared. In-flight read data arriving after reset is dropped per the empty rule.

Decomposition:
- Package enet_ddr_arb_pkg: state enum {IDLE, WR, RD}; port id constants P0=0, P1=1.
- One sub-module: enet_arb_tag_fifo. Synchronous 1-bit FIFO, depth TAG_DEPTH, with full/empty/count, same i_clk/i_rst.

Test Plan:
- Single write: p0 wr_req, addr 0x100, be 0xFFFFFFFF; DDR acks 3 cycles later -> o_ddr_wr_req high from cycle 1 to the ack cycle; o_p0_wr_ack single pulse; DDR addr/data match.
- Contention: p0 and p1 both wr_req continuously, DDR acks immediately -> grants alternate P0,P1,P0,P1 with 1 IDLE cycle between each.
- Read routing: p0 reads 0x200, then p1 reads 0x300; DDR returns two valid beats in order -> first on o_p0_rd_data_valid, second on o_p1; o_outstanding 0->1->2->1->0.
- FIFO full: TAG_DEPTH=4, p1 issues 5 reads with no data returned -> 4 rd_acks; 5th held until one rd_data_valid, then granted. A p0 write during the stall still completes.
- Same-port priority: p0 asserts wr_req and rd_req together -> write granted first, read on the next arbitration.
- Reset mid-RD: i_rst during RD with 2 outstanding -> next cycle o_ddr_rd_req=0, o_outstanding=0; a late rd_data_valid raises no port valid.
